// File: rtl/intersection_pkg.sv
// Shared constants for the two-road intersection controller: one-hot state
// encodings, lamp vector bit positions and default phase durations.
package intersection_pkg;

  localparam logic [6:0] S_OFF       = 7'b000_0001;
  localparam logic [6:0] S_NS_GREEN  = 7'b000_0010;
  localparam logic [6:0] S_NS_YELLOW = 7'b000_0100;
  localparam logic [6:0] S_ALL_RED_1 = 7'b000_1000;
  localparam logic [6:0] S_EW_GREEN  = 7'b001_0000;
  localparam logic [6:0] S_EW_YELLOW = 7'b010_0000;
  localparam logic [6:0] S_ALL_RED_2 = 7'b100_0000;

  typedef enum logic [6:0] {
    ST_OFF       = S_OFF,
    ST_NS_GREEN  = S_NS_GREEN,
    ST_NS_YELLOW = S_NS_YELLOW,
    ST_ALL_RED_1 = S_ALL_RED_1,
    ST_EW_GREEN  = S_EW_GREEN,
    ST_EW_YELLOW = S_EW_YELLOW,
    ST_ALL_RED_2 = S_ALL_RED_2
  } state_t;

  localparam int L_NS_RED    = 5;
  localparam int L_NS_YELLOW = 4;
  localparam int L_NS_GREEN  = 3;
  localparam int L_EW_RED    = 2;
  localparam int L_EW_YELLOW = 1;
  localparam int L_EW_GREEN  = 0;

  localparam int DEF_GREEN_TICKS  = 10;
  localparam int DEF_YELLOW_TICKS = 3;
  localparam int DEF_ALLRED_TICKS = 2;
  localparam int DEF_FLASH_TICKS  = 4;
  localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Per-phase tick counter: clears on request, counts up and holds at the
// terminal value, flagging expiry while it sits there.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != i_term)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == i_term);

endmodule

// File: rtl/intersection_ctrl.sv
// Main/side road intersection scheduler with latched side-road requests.
// Optional macro INTERSECTION_FLASH_EN flashes both yellows while OFF.
import intersection_pkg::*;

module intersection_ctrl #(
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int FLASH_TICKS  = DEF_FLASH_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ew_car,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [6:0] state_out,
  output logic       ew_pending,
  output logic [7:0] cycle_cnt
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] w_term;
  logic [5:0]       w_lamps;
  logic             w_expired;
  logic             w_clr;
  logic             r_ew_pending;
  logic [7:0]       r_cycle_cnt;

`ifdef INTERSECTION_FLASH_EN
  logic [CNT_W-1:0] r_flash_cnt;
  logic             r_flash_on;

  always_ff @(posedge clk) begin
    if (!rst_n || (r_state != ST_OFF)) begin
      r_flash_cnt <= '0;
      r_flash_on  <= 1'b1;
    end else if (r_flash_cnt == CNT_W'(FLASH_TICKS - 1)) begin
      r_flash_cnt <= '0;
      r_flash_on  <= ~r_flash_on;
    end else begin
      r_flash_cnt <= r_flash_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_next;
    end
  end

  // OFF never waits on the timer, so its terminal value is don't-care.
  always_comb begin
    w_next  = ST_OFF;
    w_term  = CNT_W'(FLASH_TICKS - 1);
    w_lamps = '0;
    case (r_state)
      ST_OFF: begin
        w_next = ST_ALL_RED_2;
`ifdef INTERSECTION_FLASH_EN
        w_lamps[L_NS_YELLOW] = r_flash_on;
        w_lamps[L_EW_YELLOW] = r_flash_on;
`endif
      end
      ST_NS_GREEN: begin
        w_term  = CNT_W'(GREEN_TICKS - 1);
        w_next  = (w_expired && r_ew_pending) ? ST_NS_YELLOW : ST_NS_GREEN;
        w_lamps[L_NS_GREEN] = 1'b1;
        w_lamps[L_EW_RED]   = 1'b1;
      end
      ST_NS_YELLOW: begin
        w_term  = CNT_W'(YELLOW_TICKS - 1);
        w_next  = w_expired ? ST_ALL_RED_1 : ST_NS_YELLOW;
        w_lamps[L_NS_YELLOW] = 1'b1;
        w_lamps[L_EW_RED]    = 1'b1;
      end
      ST_ALL_RED_1: begin
        w_term  = CNT_W'(ALLRED_TICKS - 1);
        w_next  = w_expired ? ST_EW_GREEN : ST_ALL_RED_1;
        w_lamps[L_NS_RED] = 1'b1;
        w_lamps[L_EW_RED] = 1'b1;
      end
      ST_EW_GREEN: begin
        w_term  = CNT_W'(GREEN_TICKS - 1);
        w_next  = w_expired ? ST_EW_YELLOW : ST_EW_GREEN;
        w_lamps[L_EW_GREEN] = 1'b1;
        w_lamps[L_NS_RED]   = 1'b1;
      end
      ST_EW_YELLOW: begin
        w_term  = CNT_W'(YELLOW_TICKS - 1);
        w_next  = w_expired ? ST_ALL_RED_2 : ST_EW_YELLOW;
        w_lamps[L_EW_YELLOW] = 1'b1;
        w_lamps[L_NS_RED]    = 1'b1;
      end
      ST_ALL_RED_2: begin
        w_term  = CNT_W'(ALLRED_TICKS - 1);
        w_next  = w_expired ? ST_NS_GREEN : ST_ALL_RED_2;
        w_lamps[L_NS_RED] = 1'b1;
        w_lamps[L_EW_RED] = 1'b1;
      end
      default: begin
        w_next = ST_OFF;
      end
    endcase
    if (!enable) begin
      w_next = ST_OFF;
    end
  end

  assign w_clr = !enable || (w_next != r_state);

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_en     (enable),
    .i_term   (w_term),
    .o_expired(w_expired)
  );

  // Being served in EW_GREEN consumes the request, even if a car is present.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ew_pending <= 1'b0;
      r_cycle_cnt  <= '0;
    end else begin
      if (r_state == ST_EW_GREEN) begin
        r_ew_pending <= 1'b0;
      end else if (ew_car) begin
        r_ew_pending <= 1'b1;
      end
      if (enable && (r_state == ST_EW_YELLOW) && w_expired) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
    end
  end

  assign ns_red     = w_lamps[L_NS_RED];
  assign ns_yellow  = w_lamps[L_NS_YELLOW];
  assign ns_green   = w_lamps[L_NS_GREEN];
  assign ew_red     = w_lamps[L_EW_RED];
  assign ew_yellow  = w_lamps[L_EW_YELLOW];
  assign ew_green   = w_lamps[L_EW_GREEN];
  assign state_out  = r_state;
  assign ew_pending = r_ew_pending;
  assign cycle_cnt  = r_cycle_cnt;

endmodule
